// File: rtl/mult_pkg.sv
// Shared types and constants for the sequential radix-2 Booth multiplier.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  // {q0, q(-1)} encodings that select the accumulator operation
  localparam logic [1:0] BOOTH_NOP = 2'b00;
  localparam logic [1:0] BOOTH_ADD = 2'b01;
  localparam logic [1:0] BOOTH_SUB = 2'b10;

  // Step counter must hold 0..N2_W with headroom
  function automatic int cnt_w(input int n2_w);
    return $clog2(n2_w + 2);
  endfunction

endpackage

// File: rtl/booth_step.sv
// One combinational radix-2 Booth iteration: add/sub multiplicand, then
// arithmetic-shift {acc, q, q(-1)} right by one.
module booth_step
  import mult_pkg::*;
#(
  parameter int ACC_W = 13,
  parameter int M_W   = 12,
  parameter int Q_W   = 9
) (
  input  logic [ACC_W-1:0] i_acc,
  input  logic [M_W-1:0]   i_m,
  input  logic [Q_W-1:0]   i_q,
  input  logic             i_qm1,
  output logic [ACC_W-1:0] o_acc,
  output logic [Q_W-1:0]   o_q,
  output logic             o_qm1
);

  logic [ACC_W-1:0] w_m_ext;
  logic [ACC_W-1:0] w_sum;

  // Guard bit keeps acc +/- m from overflowing for the most negative multiplicand
  assign w_m_ext = {{(ACC_W-M_W){i_m[M_W-1]}}, i_m};

  always_comb begin
    w_sum = i_acc;
    case ({i_q[0], i_qm1})
      BOOTH_ADD: w_sum = i_acc + w_m_ext;
      BOOTH_SUB: w_sum = i_acc - w_m_ext;
      BOOTH_NOP: w_sum = i_acc;
      default:   w_sum = i_acc;
    endcase
  end

  assign o_acc = {w_sum[ACC_W-1], w_sum[ACC_W-1:1]};
  assign o_q   = {w_sum[0], i_q[Q_W-1:1]};
  assign o_qm1 = i_q[0];

endmodule

// File: rtl/mult_booth_seq.sv
// Iterative radix-2 Booth multiplier with per-operand signed/unsigned mode and
// a start/busy/done handshake; one product per N2_W+2 cycles back-to-back.
//
// state | meaning
// IDLE  | waiting for start
// CALC  | one Booth step per cycle, counter 0..N2_W
// DONE  | done pulse, result valid; start here restarts immediately
module mult_booth_seq
  import mult_pkg::*;
#(
  parameter int N1_W = 11,
  parameter int N2_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic [N1_W-1:0]        n1,
  input  logic [N2_W-1:0]        n2,
  input  logic                   n1_signed,
  input  logic                   n2_signed,
  output logic                   busy,
  output logic                   done,
  output logic [N1_W+N2_W-1:0]   result
);

  localparam int RES_W = N1_W + N2_W;
  localparam int M_W   = N1_W + 1;
  localparam int ACC_W = N1_W + 2;
  localparam int Q_W   = N2_W + 1;
  localparam int CW    = cnt_w(N2_W);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [M_W-1:0]   r_m;
  logic [Q_W-1:0]   r_q;
  logic             r_qm1;
  logic [CW-1:0]    r_cnt;
  logic [RES_W-1:0] r_result;

  logic [ACC_W-1:0] w_acc_nxt;
  logic [Q_W-1:0]   w_q_nxt;
  logic             w_qm1_nxt;
  logic [RES_W-1:0] w_prod;
  logic             w_accept;
  logic             w_last;

  booth_step #(
    .ACC_W (ACC_W),
    .M_W   (M_W),
    .Q_W   (Q_W)
  ) u_step (
    .i_acc (r_acc),
    .i_m   (r_m),
    .i_q   (r_q),
    .i_qm1 (r_qm1),
    .o_acc (w_acc_nxt),
    .o_q   (w_q_nxt),
    .o_qm1 (w_qm1_nxt)
  );

  assign w_accept = start && (r_state != CALC);
  assign w_last   = (r_cnt == CW'(N2_W));
  assign w_prod   = RES_W'({w_acc_nxt, w_q_nxt});

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (start) w_state_nxt = CALC;
      CALC:    if (w_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = start ? CALC : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_acc    <= '0;
      r_m      <= '0;
      r_q      <= '0;
      r_qm1    <= 1'b0;
      r_cnt    <= '0;
      r_result <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_m   <= n1_signed ? {n1[N1_W-1], n1} : {1'b0, n1};
        r_q   <= n2_signed ? {n2[N2_W-1], n2} : {1'b0, n2};
        r_acc <= '0;
        r_qm1 <= 1'b0;
        r_cnt <= '0;
      end else if (r_state == CALC) begin
        r_acc <= w_acc_nxt;
        r_q   <= w_q_nxt;
        r_qm1 <= w_qm1_nxt;
        if (!w_last) r_cnt <= r_cnt + 1'b1;
      end
      // Loaded on the final step so the value is already valid while done is high
      if (r_state == CALC && w_last) r_result <= w_prod;
    end
  end

  assign busy   = (r_state == CALC);
  assign done   = (r_state == DONE);
  assign result = r_result;

endmodule

// File: tb/tb_mult_booth_seq.sv
// Scoreboard bench for mult_booth_seq: default 11x8 instance plus a 16x16 instance.
module tb_mult_booth_seq;

  localparam int LAT_A = 8 + 2;
  localparam int LAT_B = 16 + 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start_a, s1_a, s2_a, busy_a, done_a;
  logic [10:0] n1_a;
  logic [7:0]  n2_a;
  logic [18:0] result_a;
  logic        start_b, s1_b, s2_b, busy_b, done_b;
  logic [15:0] n1_b, n2_b;
  logic [31:0] result_b;

  mult_booth_seq u_dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .n1(n1_a), .n2(n2_a),
    .n1_signed(s1_a), .n2_signed(s2_a), .busy(busy_a), .done(done_a), .result(result_a)
  );

  mult_booth_seq #(.N1_W(16), .N2_W(16)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .n1(n1_b), .n2(n2_b),
    .n1_signed(s1_b), .n2_signed(s2_b), .busy(busy_b), .done(done_b), .result(result_b)
  );

  typedef struct {
    logic [31:0] res;
    int          cyc;
  } exp_t;

  exp_t        qa[$];
  exp_t        qb[$];
  exp_t        ea, eb;
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  logic [31:0] hold_a = '0;
  logic [31:0] hold_b = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitors: pop an expectation on every done pulse, otherwise result must hold
  always @(negedge clk) begin
    if (!rst_n) hold_a = '0;
    else if (done_a) begin
      if (qa.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done_a: got result 0x%0h expected no done", result_a);
      end else begin
        ea = qa.pop_front();
        chk("result_a", 32'(result_a), ea.res);
        chk("latency_a", 32'(cyc), 32'(ea.cyc));
        hold_a = ea.res;
      end
    end else chk("stable_a", 32'(result_a), hold_a);
  end

  always @(negedge clk) begin
    if (!rst_n) hold_b = '0;
    else if (done_b) begin
      if (qb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_done_b: got result 0x%0h expected no done", result_b);
      end else begin
        eb = qb.pop_front();
        chk("result_b", result_b, eb.res);
        chk("latency_b", 32'(cyc), 32'(eb.cyc));
        hold_b = eb.res;
      end
    end else chk("stable_b", result_b, hold_b);
  end

  task automatic issue_a(input logic [10:0] a, input logic [7:0] b,
                         input logic sa, input logic sb, input logic [18:0] exp);
    @(posedge clk); #1;
    n1_a = a; n2_a = b; s1_a = sa; s2_a = sb; start_a = 1'b1;
    qa.push_back('{32'(exp), cyc + LAT_A});
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  task automatic wait_done_a();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done_a) return;
    end
    checks++; errors++;
    $display("FAIL timeout_a: got no done expected done within 40 cycles");
  endtask

  task automatic issue_b(input logic [15:0] a, input logic [15:0] b,
                         input logic sa, input logic sb, input logic [31:0] exp);
    @(posedge clk); #1;
    n1_b = a; n2_b = b; s1_b = sa; s2_b = sb; start_b = 1'b1;
    qb.push_back('{exp, cyc + LAT_B});
    @(posedge clk); #1;
    start_b = 1'b0;
  endtask

  task automatic wait_done_b();
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (done_b) return;
    end
    checks++; errors++;
    $display("FAIL timeout_b: got no done expected done within 60 cycles");
  endtask

  function automatic logic [31:0] ref16(input logic [15:0] a, input logic [15:0] b,
                                        input logic sa, input logic sb);
    longint x, y;
    x = sa ? longint'($signed(a)) : longint'(a);
    y = sb ? longint'($signed(b)) : longint'(b);
    return 32'(x * y);
  endfunction

  initial begin
    rst_n = 1'b0;
    start_a = 1'b0; n1_a = '0; n2_a = '0; s1_a = 1'b0; s2_a = 1'b0;
    start_b = 1'b0; n1_b = '0; n2_b = '0; s1_b = 1'b0; s2_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy_a", 32'(busy_a), 32'h0);
    chk("rst_done_a", 32'(done_a), 32'h0);
    chk("rst_result_a", 32'(result_a), 32'h0);
    chk("rst_busy_b", 32'(busy_b), 32'h0);
    chk("rst_result_b", result_b, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Signed corners and latency
    issue_a(11'h555, 8'h55, 1'b1, 1'b1, 19'h71D39); wait_done_a();
    issue_a(11'h7FF, 8'h80, 1'b1, 1'b1, 19'h00080); wait_done_a();
    issue_a(11'h400, 8'h80, 1'b1, 1'b1, 19'h20000); wait_done_a();
    // Unsigned and mixed
    issue_a(11'h7FF, 8'hFF, 1'b0, 1'b0, 19'h7F701); wait_done_a();
    issue_a(11'h7FF, 8'hFF, 1'b1, 1'b0, 19'h7FF01); wait_done_a();
    issue_a(11'h7FF, 8'hFF, 1'b0, 1'b1, 19'h7F801); wait_done_a();
    // Zero operands
    issue_a(11'h7FF, 8'h00, 1'b1, 1'b1, 19'h00000); wait_done_a();
    issue_a(11'h003, 8'h07, 1'b0, 1'b0, 19'h00015); wait_done_a();
    issue_a(11'h000, 8'hFF, 1'b0, 1'b0, 19'h00000); wait_done_a();

    // start held during CALC with changing operands must be ignored
    @(posedge clk); #1;
    n1_a = 11'h555; n2_a = 8'h55; s1_a = 1'b1; s2_a = 1'b1; start_a = 1'b1;
    qa.push_back('{32'h71D39, cyc + LAT_A});
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      n1_a = 11'h123 + 11'(i); n2_a = 8'h3C ^ 8'(i); s1_a = ~s1_a; s2_a = ~s2_a;
      if (i == 1) chk("busy_held_start", 32'(busy_a), 32'h1);
    end
    start_a = 1'b0;
    wait_done_a();

    // Back-to-back restart from the DONE cycle
    n1_a = 11'h00A; n2_a = 8'h0C; s1_a = 1'b0; s2_a = 1'b0; start_a = 1'b1;
    qa.push_back('{32'h00078, cyc + LAT_A});
    @(posedge clk); #1;
    start_a = 1'b0;
    chk("b2b_busy", 32'(busy_a), 32'h1);
    chk("b2b_done_low", 32'(done_a), 32'h0);
    wait_done_a();

    // Reset four cycles into CALC aborts without a done pulse
    @(posedge clk); #1;
    n1_a = 11'h7FF; n2_a = 8'hFF; s1_a = 1'b0; s2_a = 1'b0; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_busy", 32'(busy_a), 32'h0);
    chk("abort_done", 32'(done_a), 32'h0);
    chk("abort_result", 32'(result_a), 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (15) @(posedge clk);

    // Wide instance: corners then random operands against a reference multiply
    issue_b(16'h8000, 16'h8000, 1'b1, 1'b1, 32'h40000000); wait_done_b();
    issue_b(16'hFFFF, 16'hFFFF, 1'b0, 1'b0, 32'hFFFE0001); wait_done_b();
    issue_b(16'hFFFF, 16'h0002, 1'b1, 1'b0, 32'hFFFFFFFE); wait_done_b();
    for (int i = 0; i < 8; i++) begin
      logic [15:0] ra, rb;
      logic        rsa, rsb;
      ra  = 16'($urandom);
      rb  = 16'($urandom);
      rsa = 1'($urandom_range(0, 1));
      rsb = 1'($urandom_range(0, 1));
      issue_b(ra, rb, rsa, rsb, ref16(ra, rb, rsa, rsb));
      wait_done_b();
    end

    repeat (5) @(posedge clk);
    chk("queue_a_drained", 32'(qa.size()), 32'h0);
    chk("queue_b_drained", 32'(qb.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got simulation still running expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
